// File: rtl/relu_backward.sv
// ReLU backward pass: in-order derivative mask buffer gating upstream gradients.
// Optional RELU_BACKWARD_LEAKY_EN: masked entries pass grad_in >>> 3 instead of 0.
module relu_backward #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     fwd_valid,
  input  logic signed [DATA_W-1:0] fwd_value,
  output logic                     fwd_ready,
  input  logic                     grad_valid,
  input  logic signed [DATA_W-1:0] grad_in,
  output logic                     grad_ready,
  output logic                     grad_out_valid,
  output logic signed [DATA_W-1:0] grad_out,
  input  logic                     grad_out_ready,
  output logic [CNT_W-1:0]         count,
  output logic                     overflow_err,
  output logic                     underflow_err
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0]         mask_q, mask_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     vld_q, vld_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;

  logic                     full, empty;
  logic                     push, pop;
  logic                     fwd_pos;
  logic signed [DATA_W-1:0] gated;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign fwd_pos = !fwd_value[DATA_W-1] && (fwd_value != '0);

  assign fwd_ready  = !full;
  assign grad_ready = !empty && (!vld_q || grad_out_ready);
  assign push       = fwd_valid && fwd_ready;
  assign pop        = grad_valid && grad_ready;

`ifdef RELU_BACKWARD_LEAKY_EN
  assign gated = mask_q[rd_ptr_q] ? grad_in : (grad_in >>> 3);
`else
  assign gated = mask_q[rd_ptr_q] ? grad_in : '0;
`endif

  always_comb begin
    mask_d   = mask_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    out_d    = out_q;
    ovf_d    = ovf_q || (fwd_valid && full);
    unf_d    = unf_q || (grad_valid && empty);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      vld_d    = 1'b0;
      out_d    = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push) begin
        mask_d[wr_ptr_q] = fwd_pos;
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        vld_d    = 1'b1;
        out_d    = gated;
      end else if (vld_q && grad_out_ready) begin
        vld_d = 1'b0;
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign grad_out_valid = vld_q;
  assign grad_out       = out_q;
  assign count          = cnt_q;
  assign overflow_err   = ovf_q;
  assign underflow_err  = unf_q;

endmodule

// File: tb/tb_relu_backward.sv
// Directed bench for relu_backward: push/pop ordering, backpressure,
// full/empty errors, pointer wrap, reset and flush.
module tb_relu_backward;
  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              fwd_valid;
  logic signed [7:0] fwd_value;
  logic              fwd_ready;
  logic              grad_valid;
  logic signed [7:0] grad_in;
  logic              grad_ready;
  logic              grad_out_valid;
  logic signed [7:0] grad_out;
  logic              grad_out_ready;
  logic [4:0]        count;
  logic              overflow_err;
  logic              underflow_err;

  int n_chk = 0;
  int n_fail = 0;

  relu_backward dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .fwd_valid      (fwd_valid),
    .fwd_value      (fwd_value),
    .fwd_ready      (fwd_ready),
    .grad_valid     (grad_valid),
    .grad_in        (grad_in),
    .grad_ready     (grad_ready),
    .grad_out_valid (grad_out_valid),
    .grad_out       (grad_out),
    .grad_out_ready (grad_out_ready),
    .count          (count),
    .overflow_err   (overflow_err),
    .underflow_err  (underflow_err)
  );

  always #5 clk = ~clk;

  function automatic int masked(input int g);
`ifdef RELU_BACKWARD_LEAKY_EN
    return g >>> 3;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int v);
    @(negedge clk);
    fwd_valid = 1'b1;
    fwd_value = 8'(v);
    #1 chk("push_ready", int'(fwd_ready), 1);
    @(posedge clk);
    #1 fwd_valid = 1'b0;
  endtask

  // Back-to-back capable: leaves grad_valid high for the next call.
  task automatic pop(input int g, input int exp);
    @(negedge clk);
    grad_valid = 1'b1;
    grad_in    = 8'(g);
    #1 chk("pop_ready", int'(grad_ready), 1);
    @(posedge clk);
    #1;
    chk("pop_valid", int'(grad_out_valid), 1);
    chk("pop_out", int'(grad_out), exp);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    grad_valid = 1'b0;
    fwd_valid  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0;
    fwd_valid = 1'b0; fwd_value = '0;
    grad_valid = 1'b0; grad_in = '0;
    grad_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(grad_out_valid), 0);
    chk("rst_out", int'(grad_out), 0);
    chk("rst_ovf", int'(overflow_err), 0);
    chk("rst_unf", int'(underflow_err), 0);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("rst_fwd_ready", int'(fwd_ready), 1);
    chk("rst_grad_ready", int'(grad_ready), 0);

    // Basic mask rule
    push(-10); push(5); push(-3); push(12); push(0);
    chk("basic_count5", int'(count), 5);
    pop(20, masked(20));
    pop(20, 20);
    pop(20, masked(20));
    pop(20, 20);
    pop(20, masked(20));
    idle_cycle();
    chk("basic_clear", int'(grad_out_valid), 0);
    chk("basic_keep", int'(grad_out), masked(20));
    chk("basic_count0", int'(count), 0);

    // Full buffer and overflow
    for (int i = 0; i < 16; i++) push(1);
    @(negedge clk);
    fwd_valid = 1'b1;
    fwd_value = 8'sd7;
    #1;
    chk("full_fwd_ready", int'(fwd_ready), 0);
    @(posedge clk);
    #1;
    chk("ovf_set", int'(overflow_err), 1);
    chk("full_count", int'(count), 16);
    fwd_valid = 1'b0;
    for (int i = 0; i < 16; i++) pop(-4, -4);
    idle_cycle();
    chk("drain_count", int'(count), 0);
    chk("ovf_sticky", int'(overflow_err), 1);

    // Empty buffer and underflow
    @(negedge clk);
    grad_valid = 1'b1;
    grad_in    = 8'sd9;
    #1 chk("empty_grad_ready", int'(grad_ready), 0);
    @(posedge clk);
    #1;
    chk("unf_set", int'(underflow_err), 1);
    chk("unf_no_out", int'(grad_out_valid), 0);
    grad_valid = 1'b0;

    // Output backpressure
    push(3); push(3);
    @(negedge clk);
    grad_out_ready = 1'b0;
    grad_valid = 1'b1;
    grad_in    = -8'sd8;
    #1 chk("hold_accept", int'(grad_ready), 1);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      grad_in = 8'sd33;
      #1;
      chk("hold_valid", int'(grad_out_valid), 1);
      chk("hold_out", int'(grad_out), -8);
      chk("hold_ready", int'(grad_ready), 0);
      chk("hold_count", int'(count), 1);
    end
    @(negedge clk);
    grad_valid = 1'b0;
    grad_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release", int'(grad_out_valid), 0);
    chk("hold_keep", int'(grad_out), -8);
    pop(1, 1);
    idle_cycle();

    // Simultaneous push/pop across pointer wrap
    push(4);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      fwd_valid  = 1'b1;
      fwd_value  = (i % 2 == 0) ? -8'sd4 : 8'sd4;
      grad_valid = 1'b1;
      grad_in    = 8'sd50;
      #1;
      chk("wrap_count", int'(count), 1);
      chk("wrap_gready", int'(grad_ready), 1);
      @(posedge clk);
      #1;
      chk("wrap_valid", int'(grad_out_valid), 1);
      chk("wrap_out", int'(grad_out), (i % 2 == 0) ? 50 : masked(50));
    end
    idle_cycle();
    chk("wrap_count_end", int'(count), 1);
    pop(50, 50);
    idle_cycle();

    // Async reset mid-stream
    for (int i = 0; i < 6; i++) push(i);
    @(negedge clk);
    grad_out_ready = 1'b0;
    pop(7, masked(7));
    grad_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", int'(count), 5);
    reset = 1'b0;
    #1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(grad_out_valid), 0);
    chk("mid_rst_out", int'(grad_out), 0);
    chk("mid_rst_unf", int'(underflow_err), 0);
    @(negedge clk) reset = 1'b1;
    grad_out_ready = 1'b1;

    // Flush mid-stream, with errors set and a competing pop
    @(negedge clk);
    grad_valid = 1'b1;
    @(posedge clk);
    #1 grad_valid = 1'b0;
    for (int i = 0; i < 16; i++) push(9);
    @(negedge clk);
    fwd_valid = 1'b1;
    @(posedge clk);
    #1 fwd_valid = 1'b0;
    chk("pre_flush_ovf", int'(overflow_err), 1);
    chk("pre_flush_unf", int'(underflow_err), 1);
    grad_out_ready = 1'b0;
    pop(5, 5);
    @(negedge clk);
    flush = 1'b1;
    grad_out_ready = 1'b1;
    grad_valid = 1'b1;
    #1 chk("flush_not_yet", int'(count), 15);
    @(posedge clk);
    #1;
    chk("flush_count", int'(count), 0);
    chk("flush_valid", int'(grad_out_valid), 0);
    chk("flush_out", int'(grad_out), 0);
    chk("flush_ovf", int'(overflow_err), 0);
    chk("flush_unf", int'(underflow_err), 0);
    flush = 1'b0;
    grad_valid = 1'b0;
    @(posedge clk);
    #1 chk("post_flush_ready", int'(fwd_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
